// File: rtl/spi_pkg.sv
// Shared types and helpers for the multi-slave SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StHold
  } spi_state_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_multi_if.sv
// Host request/response port of the SPI master. The master drives requests,
// the SPI engine sits on the slave modport.
interface spi_master_multi_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CS     = 2
) ();

  localparam int unsigned CSW = spi_pkg::width_of(NUM_CS);

  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [CSW-1:0]        cs_sel;
  logic                  cpol;
  logic                  cpha;
  logic                  lsb_first;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;

  modport master (
    output tx_valid, tx_data, cs_sel, cpol, cpha, lsb_first,
    input  tx_ready, rx_data, rx_valid, busy
  );

  modport slave (
    input  tx_valid, tx_data, cs_sel, cpol, cpha, lsb_first,
    output tx_ready, rx_data, rx_valid, busy
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV cycles while enabled and flags the
// clk edge on which each SCLK edge happens (leading, trailing, final).
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic cpol_i,
  output logic sclk_o,
  output logic lead_edge_o,
  output logic trail_edge_o,
  output logic last_edge_o
);

  localparam int unsigned DivW  = width_of(CLK_DIV);
  localparam int unsigned EdgeW = width_of(2 * DATA_WIDTH);

  logic [DivW-1:0]  div_q, div_d;
  logic [EdgeW-1:0] edge_q, edge_d;
  logic             sclk_q, sclk_d;
  logic             tick;

  assign tick         = enable_i && (div_q == DivW'(CLK_DIV - 1));
  // Edge index is zero-based, so even indices are the leading edges.
  assign lead_edge_o  = tick && !edge_q[0];
  assign trail_edge_o = tick && edge_q[0];
  assign last_edge_o  = tick && (edge_q == EdgeW'(2 * DATA_WIDTH - 1));
  assign sclk_o       = sclk_q;

  always_comb begin
    div_d  = div_q;
    edge_d = edge_q;
    sclk_d = sclk_q;
    if (!enable_i) begin
      div_d  = '0;
      edge_d = '0;
      sclk_d = cpol_i;
    end else if (tick) begin
      div_d  = '0;
      edge_d = edge_q + 1'b1;
      sclk_d = ~sclk_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      edge_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      edge_q <= edge_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised SPI master with per-frame mode, bit order and slave select.
// All outputs are registered; frame settings are latched on acceptance.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned NUM_CS     = 2,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  spi_master_multi_if.slave host,
  input  logic              miso_i,
  output logic              mosi_o,
  output logic              sclk_o,
  output logic [NUM_CS-1:0] chip_select_o
);

  localparam int unsigned CSW   = width_of(NUM_CS);
  localparam int unsigned PhMax = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned PhW   = width_of(PhMax);

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  mosi_q, mosi_d;
  logic [NUM_CS-1:0]     cs_q, cs_d;
  logic [CSW-1:0]        cs_sel_q, cs_sel_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  lsb_q, lsb_d;
  logic [PhW-1:0]        ph_cnt_q, ph_cnt_d;
  logic                  lead_seen_q, lead_seen_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  busy_q, busy_d;

  logic accept, advance, sample;
  logic lead_edge, trail_edge, last_edge;

  // Fed with cpol_d so sclk already sits at the new idle level in the first SETUP cycle.
  spi_sclk_gen #(
    .CLK_DIV    (CLK_DIV),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sclk_gen (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .enable_i     (state_q == StShift),
    .cpol_i       (cpol_d),
    .sclk_o       (sclk_o),
    .lead_edge_o  (lead_edge),
    .trail_edge_o (trail_edge),
    .last_edge_o  (last_edge)
  );

  assign accept = host.tx_valid && tx_ready_q;

  always_comb begin
    state_d     = state_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    mosi_d      = mosi_q;
    cs_sel_d    = cs_sel_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    lsb_d       = lsb_q;
    ph_cnt_d    = ph_cnt_q;
    lead_seen_d = lead_seen_q;
    advance     = 1'b0;
    sample      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          tx_sh_d     = host.tx_data;
          mosi_d      = host.lsb_first ? host.tx_data[0] : host.tx_data[DATA_WIDTH-1];
          cs_sel_d    = host.cs_sel;
          cpol_d      = host.cpol;
          cpha_d      = host.cpha;
          lsb_d       = host.lsb_first;
          ph_cnt_d    = '0;
          lead_seen_d = 1'b0;
          state_d     = StSetup;
        end
      end
      StSetup: begin
        if (ph_cnt_q == PhW'(CS_SETUP - 1)) begin
          ph_cnt_d = '0;
          state_d  = StShift;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (lead_edge) lead_seen_d = 1'b1;
        // CPHA=1 already presented bit 0 during SETUP, so the first leading edge is skipped.
        advance = cpha_q ? (lead_edge && lead_seen_q) : (trail_edge && !last_edge);
        sample  = cpha_q ? trail_edge : lead_edge;
        if (last_edge) begin
          rx_valid_d = 1'b1;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (ph_cnt_q == PhW'(CS_HOLD - 1)) begin
          ph_cnt_d = '0;
          state_d  = StIdle;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      mosi_d  = lsb_q ? tx_sh_q[1] : tx_sh_q[DATA_WIDTH-2];
      tx_sh_d = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
    end
    if (sample) begin
      rx_sh_d = lsb_q ? {miso_i, rx_sh_q[DATA_WIDTH-1:1]}
                      : {rx_sh_q[DATA_WIDTH-2:0], miso_i};
    end
    if (rx_valid_d) rx_data_d = rx_sh_d;

    tx_ready_d = (state_d == StIdle);
    busy_d     = (state_d != StIdle);
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      cs_d[i] = !(busy_d && (cs_sel_d == CSW'(i)));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      mosi_q      <= 1'b0;
      cs_q        <= '1;
      cs_sel_q    <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      ph_cnt_q    <= '0;
      lead_seen_q <= 1'b0;
      tx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      mosi_q      <= mosi_d;
      cs_q        <= cs_d;
      cs_sel_q    <= cs_sel_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsb_q       <= lsb_d;
      ph_cnt_q    <= ph_cnt_d;
      lead_seen_q <= lead_seen_d;
      tx_ready_q  <= tx_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign mosi_o        = mosi_q;
  assign chip_select_o = cs_q;
  assign host.tx_ready = tx_ready_q;
  assign host.busy     = busy_q;
  assign host.rx_data  = rx_data_q;
  assign host.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: modes, bit order, chip selects,
// back-to-back frames and mid-frame reset.
module tb_spi_master_multi;
  import spi_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned CD  = 4;
  localparam int unsigned NCS = 3;
  localparam int unsigned CSU = 2;
  localparam int unsigned CSH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_master_multi_if #(.DATA_WIDTH(DW), .NUM_CS(NCS)) host ();

  logic           miso, mosi, sclk;
  logic [NCS-1:0] cs_n;
  logic           loop_en = 1'b1;
  logic           slv_en = 1'b0;
  logic           slv_miso = 1'b0;
  logic [7:0]     slv_sh = 8'h00;
  logic [7:0]     slv_rx = 8'h00;

  assign miso = loop_en ? mosi : slv_miso;

  spi_master_multi #(
    .DATA_WIDTH (DW),
    .CLK_DIV    (CD),
    .NUM_CS     (NCS),
    .CS_SETUP   (CSU),
    .CS_HOLD    (CSH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .host          (host),
    .miso_i        (miso),
    .mosi_o        (mosi),
    .sclk_o        (sclk),
    .chip_select_o (cs_n)
  );

  // Slave model, MSB first: shifts out on falling SCLK, captures on rising SCLK.
  always @(negedge sclk) begin
    if (slv_en) begin
      slv_miso <= slv_sh[7];
      slv_sh   <= {slv_sh[6:0], 1'b0};
    end
  end
  always @(posedge sclk) begin
    if (slv_en) slv_rx <= {slv_rx[6:0], mosi};
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-frame observations filled in by run_frame.
  int             edges, first_edge, rx_cyc;
  logic [7:0]     mosi_w, rx_w;
  logic [NCS-1:0] cs_act, cs_hold, cs_after;
  logic           hp_ok, sclk_ok, pulse_ok, rdy_after, busy_act, first_mosi;

  task automatic run_frame(input logic [7:0] data, input logic [1:0] sel,
                           input logic cp, input logic ch, input logic lsb);
    logic prev;
    int   last_e;
    @(negedge clk);
    host.tx_valid  = 1'b1;
    host.tx_data   = data;
    host.cs_sel    = sel;
    host.cpol      = cp;
    host.cpha      = ch;
    host.lsb_first = lsb;
    @(negedge clk);
    // Scramble the inputs mid-frame; the latched copies must win.
    host.tx_valid  = 1'b0;
    host.tx_data   = ~data;
    host.cs_sel    = 2'd0;
    host.cpol      = ~cp;
    host.cpha      = ~ch;
    host.lsb_first = ~lsb;
    edges = 0; first_edge = 0; rx_cyc = 0; mosi_w = 8'h00; rx_w = 8'h00;
    hp_ok = 1'b1; sclk_ok = 1'b1; last_e = 0;
    cs_act = cs_n; busy_act = host.busy; first_mosi = mosi; prev = sclk;
    for (int n = 1; n <= 200 && rx_cyc == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (sclk !== prev) begin
        edges++;
        if (edges == 1) first_edge = n;
        else if (n - last_e != CD) hp_ok = 1'b0;
        last_e = n;
        prev   = sclk;
        if (edges[0] != ch) mosi_w = lsb ? {mosi, mosi_w[7:1]} : {mosi_w[6:0], mosi};
      end else if (edges == 0 && sclk !== cp) begin
        sclk_ok = 1'b0;
      end
      if (host.rx_valid === 1'b1) begin
        rx_cyc = n;
        rx_w   = host.rx_data;
        if (sclk !== cp) sclk_ok = 1'b0;
      end
    end
    @(negedge clk);
    pulse_ok = (host.rx_valid === 1'b0);
    cs_hold  = cs_n;
    if (sclk !== cp) sclk_ok = 1'b0;
    @(negedge clk);
    cs_after  = cs_n;
    rdy_after = host.tx_ready;
    if (sclk !== cp) sclk_ok = 1'b0;
  endtask

  int         rx_cnt, gap, r1, r2, edge_cnt;
  logic [7:0] rx1, rx2;
  logic       drop, prev_s;

  initial begin
    host.tx_valid = 1'b0; host.tx_data = 8'h00; host.cs_sel = 2'd0;
    host.cpol = 1'b0; host.cpha = 1'b0; host.lsb_first = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_cs", 32'(cs_n), 32'h7);
    chk("rst_busy", 32'(host.busy), 32'd0);
    chk("rst_rx_valid", 32'(host.rx_valid), 32'd0);
    chk("rst_rx_data", 32'(host.rx_data), 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_tx_ready", 32'(host.tx_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_tx_ready", 32'(host.tx_ready), 32'd1);

    // Mode 0, MSB first, loopback
    run_frame(8'hB5, 2'd0, SPI_MODE0[1], SPI_MODE0[0], 1'b0);
    chk("m0_cs_act", 32'(cs_act), 32'h6);
    chk("m0_busy", 32'(busy_act), 32'd1);
    chk("m0_first_mosi", 32'(first_mosi), 32'd1);
    chk("m0_edges", 32'(edges), 32'd16);
    chk("m0_first_edge", 32'(first_edge), 32'd7);
    chk("m0_half_period", 32'(hp_ok), 32'd1);
    chk("m0_mosi_bits", 32'(mosi_w), 32'hB5);
    chk("m0_rx_cycle", 32'(rx_cyc), 32'd67);
    chk("m0_rx_data", 32'(rx_w), 32'hB5);
    chk("m0_pulse_1cyc", 32'(pulse_ok), 32'd1);
    chk("m0_cs_hold", 32'(cs_hold), 32'h6);
    chk("m0_cs_after", 32'(cs_after), 32'h7);
    chk("m0_ready_after", 32'(rdy_after), 32'd1);
    chk("m0_sclk_idle", 32'(sclk_ok), 32'd1);

    // Mode 3 against the slave model
    slv_sh = 8'h3C; slv_en = 1'b1; loop_en = 1'b0;
    run_frame(8'hA5, 2'd0, SPI_MODE3[1], SPI_MODE3[0], 1'b0);
    @(negedge clk);
    chk("m3_sclk_high_idle", 32'(sclk), 32'd1);
    slv_en = 1'b0; loop_en = 1'b1;
    chk("m3_sclk_idle", 32'(sclk_ok), 32'd1);
    chk("m3_edges", 32'(edges), 32'd16);
    chk("m3_slave_rx", 32'(slv_rx), 32'hA5);
    chk("m3_mosi_bits", 32'(mosi_w), 32'hA5);
    chk("m3_rx_data", 32'(rx_w), 32'h3C);
    chk("m3_rx_cycle", 32'(rx_cyc), 32'd67);

    // Mode 1, LSB first
    run_frame(8'h01, 2'd0, SPI_MODE1[1], SPI_MODE1[0], 1'b1);
    chk("lsb_first_mosi", 32'(first_mosi), 32'd1);
    chk("lsb_mosi_bits", 32'(mosi_w), 32'h01);
    chk("lsb_rx_data", 32'(rx_w), 32'h01);
    chk("lsb_sclk_idle", 32'(sclk_ok), 32'd1);

    // Chip select decode, in range and out of range
    run_frame(8'h3C, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("cs1_act", 32'(cs_act), 32'h5);
    chk("cs1_hold", 32'(cs_hold), 32'h5);
    chk("cs1_rx_data", 32'(rx_w), 32'h3C);
    run_frame(8'h96, 2'd3, 1'b0, 1'b0, 1'b0);
    chk("cs3_act", 32'(cs_act), 32'h7);
    chk("cs3_hold", 32'(cs_hold), 32'h7);
    chk("cs3_busy", 32'(busy_act), 32'd1);
    chk("cs3_rx_cycle", 32'(rx_cyc), 32'd67);
    chk("cs3_rx_data", 32'(rx_w), 32'h96);

    // Back-to-back with tx_valid held high
    @(negedge clk);
    host.tx_valid = 1'b1; host.tx_data = 8'h11; host.cs_sel = 2'd0;
    host.cpol = 1'b0; host.cpha = 1'b0; host.lsb_first = 1'b0;
    @(negedge clk);
    host.tx_data = 8'h22;
    rx_cnt = 0; gap = 0; r1 = 0; r2 = 0; rx1 = 8'h00; rx2 = 8'h00; drop = 1'b0;
    for (int n = 1; n <= 400 && rx_cnt < 2; n++) begin
      if (n > 1) @(negedge clk);
      if (drop) begin host.tx_valid = 1'b0; drop = 1'b0; end
      if (rx_cnt == 1 && cs_n === 3'h7) gap++;
      if (host.tx_ready === 1'b1 && host.tx_valid === 1'b1) drop = 1'b1;
      if (host.rx_valid === 1'b1) begin
        rx_cnt++;
        if (rx_cnt == 1) begin rx1 = host.rx_data; r1 = n; end
        else begin rx2 = host.rx_data; r2 = n; end
      end
    end
    host.tx_valid = 1'b0;
    chk("b2b_rx_count", 32'(rx_cnt), 32'd2);
    chk("b2b_rx1", 32'(rx1), 32'h11);
    chk("b2b_rx2", 32'(rx2), 32'h22);
    chk("b2b_cs_gap", 32'(gap), 32'd1);
    chk("b2b_spacing", 32'(r2 - r1), 32'd69);
    repeat (4) @(negedge clk);
    chk("b2b_no_third", 32'(host.busy), 32'd0);

    // Reset at the 5th SCLK edge
    @(negedge clk);
    host.tx_valid = 1'b1; host.tx_data = 8'h77; host.cs_sel = 2'd0;
    @(negedge clk);
    host.tx_valid = 1'b0;
    edge_cnt = 0; prev_s = sclk;
    for (int n = 1; n <= 100 && edge_cnt < 5; n++) begin
      @(negedge clk);
      if (sclk !== prev_s) begin edge_cnt++; prev_s = sclk; end
    end
    chk("mid_edge_reached", 32'(edge_cnt), 32'd5);
    chk("mid_pre_sclk", 32'(sclk), 32'd1);
    chk("mid_pre_mosi", 32'(mosi), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_sclk", 32'(sclk), 32'd0);
    chk("mid_mosi", 32'(mosi), 32'd0);
    chk("mid_cs", 32'(cs_n), 32'h7);
    chk("mid_busy", 32'(host.busy), 32'd0);
    chk("mid_tx_ready", 32'(host.tx_ready), 32'd0);
    chk("mid_rx_data", 32'(host.rx_data), 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_rx_valid", 32'(host.rx_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", 32'(host.tx_ready), 32'd1);
    run_frame(8'h5A, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("post_rx_cycle", 32'(rx_cyc), 32'd67);
    chk("post_rx_data", 32'(rx_w), 32'h5A);
    chk("post_mosi_bits", 32'(mosi_w), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
